// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter constants,
// PC index/tag extraction and BTB field widths.
package bp_pkg;

  // Counter saturation ceiling for a CNT_BITS-wide counter.
  function automatic int unsigned cnt_max(input int unsigned cnt_bits);
    return (32'd1 << cnt_bits) - 32'd1;
  endfunction

  // Weakly-taken: lowest counter value whose MSB is set.
  function automatic int unsigned cnt_weak_t(input int unsigned cnt_bits);
    return 32'd1 << (cnt_bits - 32'd1);
  endfunction

  // Weakly-not-taken: one below weakly-taken, or 0 for a 1-bit counter.
  function automatic int unsigned cnt_weak_nt(input int unsigned cnt_bits);
    return (cnt_bits == 32'd1) ? 32'd0 : (32'd1 << (cnt_bits - 32'd1)) - 32'd1;
  endfunction

  function automatic int unsigned btb_tag_bits(input int unsigned data_len,
                                               input int unsigned idx_bits);
    return data_len - idx_bits - 32'd2;
  endfunction

  // Word-aligned PCs: the two LSBs never take part in indexing.
  function automatic logic [63:0] pc_idx(input logic [63:0] pc,
                                         input int unsigned idx_bits);
    return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc,
                                         input int unsigned idx_bits);
    return pc >> (idx_bits + 32'd2);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table of saturating counters with a combinational read port
// and a registered update port. BP_GSHARE_EN folds a global history into the index.
module bp_pht
  import bp_pkg::*;
#(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_taken,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken,
  input  logic                upd_alloc
);

  localparam int unsigned DEPTH = 32'd1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_MAX     = CNT_BITS'(cnt_max(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_WEAK_T  = CNT_BITS'(cnt_weak_t(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CNT_WEAK_NT = CNT_BITS'(cnt_weak_nt(CNT_BITS));

  logic [CNT_BITS-1:0] pht_q [DEPTH];
  logic [CNT_BITS-1:0] pht_d [DEPTH];
  logic [IDX_BITS-1:0] rd_pidx;
  logic [IDX_BITS-1:0] up_pidx;

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;
  logic [IDX_BITS-1:0] ghr_d;

  assign rd_pidx = rd_idx ^ ghr_q;
  assign up_pidx = upd_idx ^ ghr_q;

  // History shifts only on resolved conditional branches.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_en) ghr_d = IDX_BITS'({ghr_q, upd_taken});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  assign rd_pidx = rd_idx;
  assign up_pidx = upd_idx;
`endif

  assign rd_taken = pht_q[rd_pidx][CNT_BITS-1];

  always_comb begin
    pht_d = pht_q;
    if (upd_en) begin
      if (upd_alloc)                          pht_d[up_pidx] = CNT_WEAK_T;
      else if (upd_taken) begin
        if (pht_q[up_pidx] != CNT_MAX)        pht_d[up_pidx] = pht_q[up_pidx] + CNT_BITS'(1);
      end else if (pht_q[up_pidx] != '0)      pht_d[up_pidx] = pht_q[up_pidx] - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_WEAK_NT;
    end else begin
      pht_q <= pht_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB plus counter PHT, trained from EX.
// Define BP_GSHARE_EN to index the PHT with gshare instead of bimodal.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned BTB_DEPTH = 16,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned PERF_LEN  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] lookup_pc,
  output logic                pred_taken,
  output logic [DATA_LEN-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [DATA_LEN-1:0] upd_pc,
  input  logic                upd_is_jal,
  input  logic                upd_taken,
  input  logic [DATA_LEN-1:0] upd_target,
  input  logic                upd_pred_taken,
  input  logic [DATA_LEN-1:0] upd_pred_target,
  output logic                mispredict,
  output logic [DATA_LEN-1:0] redirect_pc,
  output logic [PERF_LEN-1:0] perf_br_cnt,
  output logic [PERF_LEN-1:0] perf_mispred_cnt
);

  localparam int unsigned IDX_BITS = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_BITS = btb_tag_bits(DATA_LEN, IDX_BITS);

  logic [BTB_DEPTH-1:0] valid_q, valid_d;
  logic [BTB_DEPTH-1:0] jal_q, jal_d;
  logic [TAG_BITS-1:0]  tag_q [BTB_DEPTH];
  logic [TAG_BITS-1:0]  tag_d [BTB_DEPTH];
  logic [DATA_LEN-1:0]  tgt_q [BTB_DEPTH];
  logic [DATA_LEN-1:0]  tgt_d [BTB_DEPTH];
  logic [PERF_LEN-1:0]  perf_br_q, perf_br_d;
  logic [PERF_LEN-1:0]  perf_mis_q, perf_mis_d;

  logic [IDX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0] lk_tag, up_tag;
  logic                lk_hit, up_hit, lk_cnt_taken, mispred_c;

  assign lk_idx = IDX_BITS'(pc_idx(64'(lookup_pc), IDX_BITS));
  assign up_idx = IDX_BITS'(pc_idx(64'(upd_pc), IDX_BITS));
  assign lk_tag = TAG_BITS'(pc_tag(64'(lookup_pc), IDX_BITS));
  assign up_tag = TAG_BITS'(pc_tag(64'(upd_pc), IDX_BITS));

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  bp_pht #(
    .IDX_BITS (IDX_BITS),
    .CNT_BITS (CNT_BITS)
  ) u_pht (
    .clk       (clk),
    .rst_n     (reset),
    .rd_idx    (lk_idx),
    .rd_taken  (lk_cnt_taken),
    .upd_en    (upd_valid && !upd_is_jal),
    .upd_idx   (up_idx),
    .upd_taken (upd_taken),
    .upd_alloc (upd_taken && !up_hit)
  );

  // Lookup reads pre-update state, so a same-cycle update is seen one cycle later.
  assign pred_taken  = lk_hit && (jal_q[lk_idx] || lk_cnt_taken);
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + DATA_LEN'(4);

  assign mispred_c   = upd_valid && ((upd_taken != upd_pred_taken) ||
                                     (upd_taken && (upd_target != upd_pred_target)));
  assign mispredict  = mispred_c;
  assign redirect_pc = !upd_valid ? '0 :
                       (upd_taken ? upd_target : upd_pc + DATA_LEN'(4));

  assign perf_br_cnt      = perf_br_q;
  assign perf_mispred_cnt = perf_mis_q;

  // BTB training: taken outcomes refresh a hit or replace the direct-mapped slot.
  always_comb begin
    valid_d = valid_q;
    jal_d   = jal_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_valid && upd_taken) begin
      tgt_d[up_idx] = upd_target;
      if (!up_hit) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        jal_d[up_idx]   = upd_is_jal;
      end
    end
  end

  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (upd_valid && (perf_br_q != '1))  perf_br_d  = perf_br_q + PERF_LEN'(1);
    if (mispred_c && (perf_mis_q != '1)) perf_mis_d = perf_mis_q + PERF_LEN'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q    <= '0;
      jal_q      <= '0;
      perf_br_q  <= '0;
      perf_mis_q <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      jal_q      <= jal_d;
      tag_q      <= tag_d;
      tgt_q      <= tgt_d;
      perf_br_q  <= perf_br_d;
      perf_mis_q <= perf_mis_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: reference model feeds a scoreboard
// of expected lookup/resolve outputs, compared each cycle.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_jal, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, perf_br_cnt, perf_mispred_cnt;

  branch_predictor dut (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_is_jal(upd_is_jal), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .perf_br_cnt(perf_br_cnt), .perf_mispred_cnt(perf_mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (BTB_DEPTH=16, CNT_BITS=2)
  logic        m_valid [16];
  logic        m_jal   [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int unsigned m_pht   [16];
  logic [3:0]  m_ghr;
  int unsigned m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_jal[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_pht[i] = 1;
    end
    m_ghr = '0; m_br = 0; m_mis = 0;
  endtask

  function automatic int unsigned m_pidx(input logic [3:0] idx);
`ifdef BP_GSHARE_EN
    return 32'(idx ^ m_ghr);
`else
    return 32'(idx);
`endif
  endfunction

  function automatic logic [32:0] m_lookup(input logic [31:0] pc);
    logic [3:0] i;
    logic       hit, t;
    i   = pc[5:2];
    hit = m_valid[i] && (m_tag[i] == pc[31:6]);
    t   = hit && (m_jal[i] || (m_pht[m_pidx(i)] >= 2));
    return {t, t ? m_tgt[i] : pc + 32'd4};
  endfunction

  // Drive one cycle of inputs, push the model's expectation, then advance the model.
  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ujal, input logic ut, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    exp_t        e;
    logic [3:0]  ui;
    logic        hit;
    int unsigned pi;
    @(negedge clk);
    lookup_pc = lpc; upd_valid = uv; upd_pc = upc; upd_is_jal = ujal; upd_taken = ut;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    {e.pt, e.ptgt} = m_lookup(lpc);
    e.mp  = uv && ((ut != upt) || (ut && (utgt != uptgt)));
    e.rpc = !uv ? 32'd0 : (ut ? utgt : upc + 32'd4);
    exp_q.push_back(e);
    if (uv) begin
      m_br++;
      if (e.mp) m_mis++;
      ui  = upc[5:2];
      hit = m_valid[ui] && (m_tag[ui] == upc[31:6]);
      pi  = m_pidx(ui);
      if (!ujal) begin
        if (ut && !hit) m_pht[pi] = 2;
        else if (ut)    m_pht[pi] = (m_pht[pi] == 3) ? 3 : m_pht[pi] + 1;
        else            m_pht[pi] = (m_pht[pi] == 0) ? 0 : m_pht[pi] - 1;
        m_ghr = {m_ghr[2:0], ut};
      end
      if (ut) begin
        m_tgt[ui] = utgt;
        if (!hit) begin m_valid[ui] = 1'b1; m_tag[ui] = upc[31:6]; m_jal[ui] = ujal; end
      end
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    drive(lpc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_is_jal = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pred_taken, pred_target, mispredict, redirect_pc} !== {1'b0, 32'h104, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs got pt=%0b tgt=%h mp=%0b rpc=%h want 0/00000104/0/00000000",
               pred_taken, pred_target, mispredict, redirect_pc);
    end
    checks++;
    if ({perf_br_cnt, perf_mispred_cnt} !== 64'd0) begin
      errors++;
      $display("FAIL reset_perf got br=%0d mis=%0d want 0/0", perf_br_cnt, perf_mispred_cnt);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_cond_train();
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      case (s)
        0:       drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        1, 6:    idle(32'h100);
        5:       drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
        default: drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
        errors++;
        $display("FAIL cond_step%0d got %h want %h", s,
                 {pred_taken, pred_target, mispredict, redirect_pc}, e);
      end
      if (s == 0) begin
        checks++;
        if ({pred_taken, mispredict, redirect_pc} !== {1'b0, 1'b1, 32'h80}) begin
          errors++;
          $display("FAIL cond_first_resolve got pt=%0b mp=%0b rpc=%h want 0/1/00000080",
                   pred_taken, mispredict, redirect_pc);
        end
      end
      if (s == 5) begin
        checks++;
        if ({mispredict, redirect_pc} !== {1'b1, 32'h104}) begin
          errors++;
          $display("FAIL cond_not_taken got mp=%0b rpc=%h want 1/00000104", mispredict, redirect_pc);
        end
      end
    end
  endtask

  task automatic test_jal_alias();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0:       drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
        1:       idle(32'h40);
        default: idle(32'h440);
      endcase
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
        errors++;
        $display("FAIL jal_step%0d got %h want %h", s,
                 {pred_taken, pred_target, mispredict, redirect_pc}, e);
      end
    end
    checks++;
    if ({pred_taken, pred_target} !== {1'b0, 32'h444}) begin
      errors++;
      $display("FAIL jal_alias got pt=%0b tgt=%h want 0/00000444", pred_taken, pred_target);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] pcs [6];
    logic [31:0] upc, utgt;
    logic        ujal, ut;
    pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h40;
    pcs[3] = 32'h440; pcs[4] = 32'h1000; pcs[5] = 32'h104;
    for (int c = 0; c < 60; c++) begin
      upc  = pcs[$urandom_range(0, 5)];
      ujal = ($urandom_range(0, 3) == 0);
      ut   = ujal ? 1'b1 : 1'($urandom_range(0, 1));
      utgt = 32'($urandom_range(0, 255)) << 2;
      drive(pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), upc, ujal, ut, utgt,
            1'($urandom_range(0, 1)), $urandom_range(0, 1) ? utgt : utgt + 32'd4);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
        errors++;
        $display("FAIL b2b_cycle%0d got %h want %h", c,
                 {pred_taken, pred_target, mispredict, redirect_pc}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({perf_br_cnt, perf_mispred_cnt} !== {m_br, m_mis}) begin
      errors++;
      $display("FAIL b2b_perf got br=%0d mis=%0d want %0d/%0d",
               perf_br_cnt, perf_mispred_cnt, m_br, m_mis);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drive(32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    #1; void'(exp_q.pop_front());
    drive(32'h40, 1'b1, 32'h180, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
      errors++;
      $display("FAIL rstmid_pre got %h want %h", {pred_taken, pred_target, mispredict, redirect_pc}, e);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({pred_taken, pred_target, perf_br_cnt} !== {1'b0, 32'h44, 32'd0}) begin
      errors++;
      $display("FAIL rstmid_async got pt=%0b tgt=%h br=%0d want 0/00000044/0",
               pred_taken, pred_target, perf_br_cnt);
    end
    upd_valid = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      idle(s == 0 ? 32'h180 : 32'h40);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
        errors++;
        $display("FAIL rstmid_post%0d got %h want %h", s,
                 {pred_taken, pred_target, mispredict, redirect_pc}, e);
      end
    end
  endtask

  task automatic test_alternating();
    exp_t        e;
    logic [32:0] p;
    reset = 1'b0;
    model_reset();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      p = m_lookup(32'h100);
      drive(32'h100, 1'b1, 32'h100, 1'b0, (i % 2) == 0, 32'h80, p[32], p[31:0]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({pred_taken, pred_target, mispredict, redirect_pc} !== e) begin
        errors++;
        $display("FAIL alt_iter%0d got %h want %h", i,
                 {pred_taken, pred_target, mispredict, redirect_pc}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({perf_br_cnt, perf_mispred_cnt} !== {32'd20, m_mis}) begin
      errors++;
      $display("FAIL alt_perf got br=%0d mis=%0d want 20/%0d", perf_br_cnt, perf_mispred_cnt, m_mis);
    end
    checks++;
`ifdef BP_GSHARE_EN
    if (!(perf_mispred_cnt < 32'd6)) begin
      errors++;
      $display("FAIL alt_gshare_bound got mis=%0d want <6", perf_mispred_cnt);
    end
`else
    if (!(perf_mispred_cnt >= 32'd9)) begin
      errors++;
      $display("FAIL alt_bimodal_bound got mis=%0d want >=9", perf_mispred_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cond_train();
    test_jal_alias();
    test_back_to_back();
    test_reset_mid();
    test_alternating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
